// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and entry type for the writeback arbiter
package wb_pkg;

  localparam int WB_WORD         = 32;
  localparam int WB_ADDR_W       = 5;
  localparam logic [WB_ADDR_W-1:0] WB_ZERO_REG = 5'b00000;
  localparam int WB_LSU_DEPTH    = 2;
  localparam int WB_STARVE_LIMIT = 4;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_WORD-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - LSU result FIFO with per-entry destination compare
// Depth must be a power of two so the pointers wrap on overflow.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_LSU_DEPTH,
  parameter logic [WB_ADDR_W-1:0] ZERO_ADDR = WB_ZERO_REG
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WB_ADDR_W-1:0] push_addr,
  input  logic [WB_WORD-1:0]   push_data,
  input  logic                 pop,
  output logic [WB_ADDR_W-1:0] head_addr,
  output logic [WB_WORD-1:0]   head_data,
  output logic                 full,
  output logic                 empty,
  input  logic [WB_ADDR_W-1:0] chk_addr,
  output logic                 chk_hit
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] live;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = mem[rd_ptr].addr;
  assign head_data = mem[rd_ptr].data;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: push_addr, data: push_data};
    end
  end

  // When full, push and pop hit the same slot; the push must leave it live.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      live   <= '0;
    end else begin
      if (pop) begin
        rd_ptr       <= rd_ptr + PW'(1);
        live[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr       <= wr_ptr + PW'(1);
        live[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (mem[i].addr == chk_addr)) begin
        chk_hit = 1'b1;
      end
    end
    if (chk_addr == ZERO_ADDR) begin
      chk_hit = 1'b0;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging ALU and LSU results onto the register-file write port
// Optional combinational bypass outputs are enabled by defining WB_BYPASS_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH        = WB_WORD,
  parameter int ADDR_SPACE   = WB_ADDR_W,
  parameter logic [ADDR_SPACE-1:0] ZERO_REGISTER = WB_ZERO_REG,
  parameter int LSU_DEPTH    = WB_LSU_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_SPACE-1:0] alu_addr,
  input  logic [WIDTH-1:0]      alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_SPACE-1:0] lsu_addr,
  input  logic [WIDTH-1:0]      lsu_data,
  output logic                  wr_en,
  output logic [ADDR_SPACE-1:0] wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_SPACE-1:0] chk_addr,
  output logic                  chk_pending
`ifdef WB_BYPASS_EN
  ,
  output logic                  byp_valid,
  output logic [ADDR_SPACE-1:0] byp_addr,
  output logic [WIDTH-1:0]      byp_data
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_ne;
  logic                  fifo_hit;
  logic                  force_lsu;
  logic                  grant_alu;
  logic                  grant_lsu;
  logic                  granted;
  logic                  push;
  logic [ADDR_SPACE-1:0] head_addr;
  logic [WIDTH-1:0]      head_data;
  logic [ADDR_SPACE-1:0] win_addr;
  logic [WIDTH-1:0]      win_data;
  logic [SW-1:0]         starve_cnt;

  // Handshake readies are gated by reset so nothing transfers while rst is low.
  assign fifo_ne   = !fifo_empty;
  assign force_lsu = fifo_ne && (starve_cnt == SW'(STARVE_LIMIT));
  assign alu_ready = rst && !force_lsu;
  assign grant_alu = alu_valid && alu_ready;
  assign grant_lsu = rst && fifo_ne && !grant_alu;
  assign granted   = grant_alu || grant_lsu;
  assign lsu_ready = rst && (!fifo_full || grant_lsu);
  assign push      = lsu_valid && lsu_ready;

  assign win_addr  = grant_alu ? alu_addr : head_addr;
  assign win_data  = grant_alu ? alu_data : head_data;

  assign chk_pending = rst && (fifo_hit || (wr_en && (wr_addr == chk_addr)));

`ifdef WB_BYPASS_EN
  assign byp_valid = granted && (win_addr != ZERO_REGISTER);
  assign byp_addr  = win_addr;
  assign byp_data  = win_data;
`endif

  wb_result_fifo #(
    .DEPTH     (LSU_DEPTH),
    .ZERO_ADDR (ZERO_REGISTER)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (lsu_addr),
    .push_data (lsu_data),
    .pop       (grant_lsu),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .chk_addr  (chk_addr),
    .chk_hit   (fifo_hit)
  );

  // Zero-register grants still load wr_addr/wr_data; only wr_en is suppressed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= granted && (win_addr != ZERO_REGISTER);
      if (granted) begin
        wr_addr <= win_addr;
        wr_data <= win_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_lsu || !fifo_ne) begin
      starve_cnt <= '0;
    end else if (grant_alu && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed and randomized checks of wb_arbiter against a queue-based reference model
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  chk_addr;
  logic        chk_pending;
`ifdef WB_BYPASS_EN
  logic        byp_valid;
  logic [4:0]  byp_addr;
  logic [31:0] byp_data;
`endif

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_addr    (lsu_addr),
    .lsu_data    (lsu_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .chk_addr    (chk_addr),
    .chk_pending (chk_pending)
`ifdef WB_BYPASS_EN
    ,
    .byp_valid   (byp_valid),
    .byp_addr    (byp_addr),
    .byp_data    (byp_data)
`endif
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  int          checks = 0;
  int          errors = 0;
  ent_t        q[$];
  int          starve;
  logic        m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  logic        acc_alu;
  logic        acc_lsu;
  logic        obs_ar;
  logic        obs_lr;
  logic        obs_pend;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare combinational outputs, step the model, compare wr_* after the edge.
  task automatic cycle(input logic r,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic [4:0] ca);
    logic e_ar, e_lr, e_pend, g_alu, g_lsu, ne;
    ent_t win;
    rst = r; alu_valid = av; alu_addr = aa; alu_data = ad;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld; chk_addr = ca;
    #1;
    ne = (q.size() != 0);
    win = '{5'd0, 32'd0};
    if (!r) begin
      e_ar = 1'b0; e_lr = 1'b0; e_pend = 1'b0; g_alu = 1'b0; g_lsu = 1'b0;
    end else begin
      e_ar  = !(ne && starve == LIMIT);
      g_alu = av && e_ar;
      g_lsu = ne && !g_alu;
      e_lr  = (q.size() < DEPTH) || g_lsu;
      e_pend = m_wr_en && (m_wr_addr == ca);
      if (ca != 5'd0) begin
        foreach (q[i]) if (q[i].a == ca) e_pend = 1'b1;
      end
      if (g_alu) win = '{aa, ad};
      else if (g_lsu) win = q[0];
    end
    obs_ar = alu_ready; obs_lr = lsu_ready; obs_pend = chk_pending;
    check("alu_ready", alu_ready, e_ar);
    check("lsu_ready", lsu_ready, e_lr);
    check("chk_pending", chk_pending, e_pend);
`ifdef WB_BYPASS_EN
    check("byp_valid", byp_valid, (g_alu || g_lsu) && win.a != 5'd0);
    if (g_alu || g_lsu) begin
      check("byp_addr", byp_addr, win.a);
      check("byp_data", byp_data, win.d);
    end
`endif
    if (!r) begin
      q.delete(); starve = 0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
    end else begin
      if (g_lsu) void'(q.pop_front());
      if (g_alu || g_lsu) begin
        m_wr_en = (win.a != 5'd0); m_wr_addr = win.a; m_wr_data = win.d;
      end else begin
        m_wr_en = 1'b0;
      end
      if (g_lsu || !ne) starve = 0;
      else if (g_alu && starve < LIMIT) starve++;
      if (lv && e_lr) q.push_back('{la, ld});
    end
    acc_alu = g_alu;
    acc_lsu = r && lv && e_lr;
    @(posedge clk);
    #1;
    check("wr_en", wr_en, m_wr_en);
    check("wr_addr", wr_addr, m_wr_addr);
    check("wr_data", wr_data, m_wr_data);
  endtask

  logic        rav, rlv, rr;
  logic [4:0]  raa, rla;
  logic [31:0] rad, rld;

  initial begin
    rst = 1'b0; alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0; chk_addr = '0;
    starve = 0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
    acc_alu = 1'b0; acc_lsu = 1'b0;

    // Reset
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 7, 1, 1, 7, 2, 7);
    check("rst_alu_ready", obs_ar, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_data", wr_data, 32'd0);

    // ALU write to r7
    cycle(1, 1, 7, 59, 0, 0, 0, 0);
    check("t1_alu_ready", obs_ar, 1'b1);
    check("t1_wr_en", wr_en, 1'b1);
    check("t1_wr_addr", wr_addr, 5'd7);
    check("t1_wr_data", wr_data, 32'd59);

    // ALU write to the zero register
    cycle(1, 1, 0, 32'hDEAD, 0, 0, 0, 0);
    check("t2_alu_ready", obs_ar, 1'b1);
    check("t2_wr_en", wr_en, 1'b0);
    check("t2_wr_data", wr_data, 32'hDEAD);

    // Two LSU results retire in order, one per cycle
    cycle(1, 0, 0, 0, 1, 3, 11, 0);
    check("t3_no_fallthrough", wr_en, 1'b0);
    cycle(1, 0, 0, 0, 1, 4, 12, 0);
    check("t3_first_addr", wr_addr, 5'd3);
    check("t3_first_data", wr_data, 32'd11);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    check("t3_second_addr", wr_addr, 5'd4);
    check("t3_second_data", wr_data, 32'd12);

    // Fill while ALU keeps winning; third push must stall
    cycle(1, 1, 1, 1, 1, 5, 21, 0);
    cycle(1, 1, 2, 2, 1, 6, 22, 0);
    cycle(1, 1, 3, 3, 1, 8, 23, 0);
    check("t3_full_stall", obs_lr, 1'b0);
    cycle(1, 0, 0, 0, 1, 8, 23, 0);
    check("t3_push_while_pop", obs_lr, 1'b1);
    check("t3_pop_addr", wr_addr, 5'd5);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    check("t3_last_data", wr_data, 32'd23);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    check("t3_drained", wr_en, 1'b0);

    // Starvation limit forces the LSU after four ALU wins
    cycle(1, 1, 1, 100, 1, 9, 5, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 1, 101 + i, 0, 0, 0, 0);
      check("t4_alu_wins", obs_ar, 1'b1);
      check("t4_alu_data", wr_data, 101 + i);
    end
    cycle(1, 1, 2, 200, 0, 0, 0, 0);
    check("t4_forced", obs_ar, 1'b0);
    check("t4_lsu_addr", wr_addr, 5'd9);
    check("t4_lsu_data", wr_data, 32'd5);
    cycle(1, 1, 2, 200, 0, 0, 0, 0);
    check("t4_alu_resumes", obs_ar, 1'b1);
    check("t4_resume_data", wr_data, 32'd200);

    // Hazard query through FIFO residency and output register
    cycle(1, 1, 1, 1, 1, 12, 77, 12);
    cycle(1, 1, 1, 2, 0, 0, 0, 12);
    check("t5_fifo_hit", obs_pend, 1'b1);
    cycle(1, 1, 1, 3, 0, 0, 0, 0);
    check("t5_zero_query", obs_pend, 1'b0);
    cycle(1, 0, 0, 0, 0, 0, 0, 12);
    cycle(1, 0, 0, 0, 0, 0, 0, 12);
    check("t5_wr_hit", obs_pend, 1'b1);
    cycle(1, 0, 0, 0, 0, 0, 0, 12);
    check("t5_retired", obs_pend, 1'b0);

    // Reset with a full FIFO leaves nothing behind
    cycle(1, 1, 1, 1, 1, 13, 1, 0);
    cycle(1, 1, 1, 2, 1, 14, 2, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_rst_wr_en", wr_en, 1'b0);
    cycle(1, 0, 0, 0, 0, 0, 0, 13);
    check("t6_no_pending", obs_pend, 1'b0);
    check("t6_lsu_ready", obs_lr, 1'b1);
    check("t6_no_stale", wr_en, 1'b0);
    cycle(1, 0, 0, 0, 0, 0, 0, 14);
    check("t6_still_idle", wr_en, 1'b0);

    // Randomized traffic; sources hold their offer until it transfers
    rav = 1'b0; rlv = 1'b0; raa = '0; rla = '0; rad = '0; rld = '0;
    repeat (600) begin
      if (!rav || acc_alu) begin
        rav = ($urandom_range(0, 3) != 0);
        raa = 5'($urandom_range(0, 7));
        rad = $urandom;
      end
      if (!rlv || acc_lsu) begin
        rlv = ($urandom_range(0, 1) != 0);
        rla = 5'($urandom_range(0, 7));
        rld = $urandom;
      end
      rr = ($urandom_range(0, 63) != 0);
      cycle(rr, rav, raa, rad, rlv, rla, rld, 5'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
